// File: rtl/demux4_router.sv
// demux4_router: one input stream steered by in_sel into four independent FIFOs.
// Optional per-channel push counters are built when DEMUX4_STATS_EN is defined.
module demux4_router #(
  parameter int DW    = 2,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_sel,
  input  logic [DW-1:0]   in_data,
  output logic [3:0]      out_valid,
  input  logic [3:0]      out_ready,
  output logic [4*DW-1:0] out_data
`ifdef DEMUX4_STATS_EN
  ,
  input  logic            stat_clr,
  output logic [31:0]     stat_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q    [4][DEPTH];
  logic [AW-1:0] wr_ptr_q [4];
  logic [AW-1:0] wr_ptr_d [4];
  logic [AW-1:0] rd_ptr_q [4];
  logic [AW-1:0] rd_ptr_d [4];
  logic [CW-1:0] count_q  [4];
  logic [CW-1:0] count_d  [4];
  logic [3:0]    full_s;
  logic [3:0]    push_s;
  logic [3:0]    pop_s;

  // Handshake decode; no bypass, so a full channel refuses even while popping
  always_comb begin
    full_s    = 4'b0000;
    push_s    = 4'b0000;
    pop_s     = 4'b0000;
    out_valid = 4'b0000;
    out_data  = '0;
    for (int k = 0; k < 4; k++) begin
      full_s[k]              = (count_q[k] == CW'(DEPTH));
      out_valid[k]           = (count_q[k] != CW'(0));
      pop_s[k]               = out_valid[k] && out_ready[k];
      out_data[k*DW +: DW]   = mem_q[k][rd_ptr_q[k]];
    end
    in_ready = ~full_s[in_sel];
    for (int k = 0; k < 4; k++) begin
      push_s[k] = in_valid && in_ready && (in_sel == 2'(k));
    end
  end

  // Next-state pointers and occupancy; pointers wrap since DEPTH is a power of two
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      wr_ptr_d[k] = wr_ptr_q[k];
      rd_ptr_d[k] = rd_ptr_q[k];
      count_d[k]  = count_q[k];
      if (push_s[k]) begin
        wr_ptr_d[k] = wr_ptr_q[k] + AW'(1);
      end else begin
        wr_ptr_d[k] = wr_ptr_q[k];
      end
      if (pop_s[k]) begin
        rd_ptr_d[k] = rd_ptr_q[k] + AW'(1);
      end else begin
        rd_ptr_d[k] = rd_ptr_q[k];
      end
      case ({push_s[k], pop_s[k]})
        2'b10:   count_d[k] = count_q[k] + CW'(1);
        2'b01:   count_d[k] = count_q[k] - CW'(1);
        default: count_d[k] = count_q[k];
      endcase
    end
  end

  // Channel storage, pointers and counts; reset discards everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        count_q[k]  <= '0;
        for (int e = 0; e < DEPTH; e++) begin
          mem_q[k][e] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
        count_q[k]  <= count_d[k];
        if (push_s[k]) begin
          mem_q[k][wr_ptr_q[k]] <= in_data;
        end
      end
    end
  end

`ifdef DEMUX4_STATS_EN
  logic [7:0] stat_q [4];
  logic [7:0] stat_d [4];

  // Per-channel push counters; clear wins over a coincident push
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      if (stat_clr) begin
        stat_d[k] = 8'd0;
      end else if (push_s[k]) begin
        stat_d[k] = stat_q[k] + 8'd1;
      end else begin
        stat_d[k] = stat_q[k];
      end
    end
    stat_count = {stat_q[3], stat_q[2], stat_q[1], stat_q[0]};
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        stat_q[k] <= 8'd0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        stat_q[k] <= stat_d[k];
      end
    end
  end
`endif

endmodule

// File: doc/demux4_router.md
# demux4_router

Four-way buffered demultiplexer, the inverse of the team's 4:1 case-statement mux. A single DW-bit input stream carries a 2-bit destination select. Each accepted word is steered into one of four per-channel FIFOs, which drain independently under valid/ready handshakes. It sits between one shared producer and four consumers that can stall individually without blocking traffic to the others.

## Interface
- DW, 2, data width of input and each output channel
- DEPTH, 2, entries per channel FIFO; power of two, minimum 2
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer offers a word
- in_ready  output  1  demux can accept a word for the current in_sel
- in_sel  input  2  destination channel 0..3; don't-care while in_valid=0
- in_data  input  DW  word to route
- out_valid  output  4  bit k: channel k FIFO non-empty
- out_ready  input  4  bit k: consumer k takes head word
- out_data  output  4*DW  channel k head word at bits [k*DW +: DW]

## Operation
- Accept (push) when in_valid && in_ready. The word is written to FIFO[in_sel].
- in_ready = ~full[in_sel]. It is combinational from in_sel and registered occupancy. There is no bypass, so a full channel refuses a push even when it pops in the same cycle.
- Pop channel k when out_valid[k] && out_ready[k]. The read pointer advances and the next entry is presented.
- out_valid[k] = (count[k] != 0). out_data[k] = storage[k][rd_ptr[k]].
- Per channel state:
  - wr_ptr and rd_ptr, each clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count, clog2(DEPTH)+1 bits.
  - full = (count == DEPTH).
- Push and pop on the same channel in the same cycle (channel neither empty nor full): count unchanged, both pointers advance.
- Push to channel j and pop from channel k≠j in the same cycle: independent, both occur.
- Channels never reorder. Words to one channel leave in acceptance order.
- in_sel containing X/Z while in_valid=1 is a producer protocol violation. The bench must flag it; the RTL makes no guarantee.
- Reset, any time including mid-transfer:
  - All counts, pointers and storage are cleared to 0.
  - out_valid = 4'b0000, out_data = 0.
  - in_ready = 1 in the first cycle after reset release.
  - Words in flight at reset are discarded.

## Timing
- Latency: a word accepted at edge N shows out_valid[k]=1 and out_data[k] valid after edge N, so it is poppable at edge N+1.
- Throughput: one push per cycle total. Up to four pops per cycle, one per channel.
- A stalled channel (out_ready[k]=0, full) lowers in_ready only while in_sel=k. The producer may change in_sel while waiting; no accept occurs in that cycle.
- in_ready→in_valid is permitted combinationally. in_valid must not depend combinationally on in_ready.
- rst is sampled only at the clock edge. A rst pulse of one cycle fully clears the state.

## Configuration
- DEMUX4_STATS_EN defined adds the following:
  - input stat_clr (1 bit): synchronous clear.
  - output stat_count (32 bits): four 8-bit counters. Byte k counts accepted pushes to channel k.
  - Counters wrap 255→0 and reset to 0 on rst or stat_clr.
  - A push coincident with stat_clr leaves the count at 0.
- DEMUX4_STATS_EN undefined: the ports and counters are absent; routing behaviour is identical.

## Test plan
- **Reset:** assert rst 2 cycles with in_valid=1, in_sel=2'b10, in_data=2'b11. Required after release: out_valid=4'b0000, out_data=0, in_ready=1.
- **Single route:** push in_sel=1, in_data=2'b10 at edge N with out_ready=0. Required after edge N: out_valid=4'b0010, out_data[3:2]=2'b10. Raise out_ready[1]; required after the next edge: out_valid=4'b0000.
- **Full/backpressure:** DEPTH=2, out_ready=0. Push 2'b01 then 2'b11 to channel 3. Required: in_ready=0 when in_sel=3, in_ready=1 when in_sel=0. A third push to channel 0 is accepted.
- **Order and wrap:** stream 6 words 0,1,2,3,0,1 to channel 2 with out_ready[2] toggling 1/0. Required: consumer 2 receives exactly 0,1,2,3,0,1 in order.
- **Simultaneous:** channel 0 holds one word. In one cycle, push 2'b11 to channel 0 and pop channel 0. Required: count stays 1, out_data[1:0]=2'b11 next cycle.
- **Stats (DEMUX4_STATS_EN):** 300 pushes to channel 1. Required: stat_count[15:8]=44 (300 mod 256). Pulse stat_clr; required: stat_count=0.
